// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the pc_fetch_unit instruction-fetch front end.
// Optional zero-latency response bypass is enabled by defining FETCH_BYPASS_EN.
package pc_fetch_unit_pkg;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } fetch_entry_t;

    // A target with bit 2 set lands on slot 1 of its pair.
    function automatic logic [1:0] first_mask(input logic [31:0] target);
        return target[2] ? 2'b10 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// Synchronous FIFO of fetched instruction pairs with a synchronous clear.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_buffer
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    output fetch_entry_t data_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && (!full_o || pop_i) && !clr_i;
        do_pop   = pop_i && !empty_o && !clr_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: PC register, one-outstanding fetch FSM and pair buffer.
// Define FETCH_BYPASS_EN to forward responses combinationally when the buffer is empty.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          FB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  stall1_i,
    input  logic [6:0]  stall2_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_gnt_i,
    input  logic        inst_rvalid_i,
    input  logic [63:0] inst_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [63:0] if_inst_o,
    output logic [1:0]  if_mask_o
);

    localparam int CW = $clog2(FB_DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [1:0]   mask_q, mask_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [1:0]   pend_mask_q, pend_mask_d;

    logic         if_stall, redirect, gnt_ok, rsp_ok, bypass;
    logic         outstanding, credit;
    logic [31:0]  target;
    logic [CW:0]  used;
    logic         fb_push, fb_pop, fb_full, fb_empty;
    logic [CW-1:0] fb_count;
    fetch_entry_t rsp_entry, fb_head, out_entry;

    assign if_stall = stall1_i[STALL_IF] | stall2_i[STALL_IF];
    assign redirect = flush_i | branch_flag_i;
    assign target   = flush_i ? new_pc_i : branch_addr_i;

    assign outstanding = (state_q != ST_REQ);
    assign used        = {1'b0, fb_count} + (CW+1)'(outstanding);
    assign credit      = !fb_full && (used < (CW+1)'(FB_DEPTH));

    // Held low while in reset so the request never leaks during rst_n.
    assign inst_req_o  = rst_n && (state_q == ST_REQ) && credit;
    assign inst_addr_o = fetch_pc_q;
    assign gnt_ok      = inst_req_o && inst_gnt_i;

    assign rsp_entry = '{pc: pend_pc_q, inst: inst_rdata_i, mask: pend_mask_q};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        mask_d      = mask_q;
        pend_pc_d   = pend_pc_q;
        pend_mask_d = pend_mask_q;
        rsp_ok      = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                if (gnt_ok) begin
                    state_d     = redirect ? ST_DROP : ST_WAIT;
                    pend_pc_d   = fetch_pc_q;
                    pend_mask_d = mask_q;
                    fetch_pc_d  = fetch_pc_q + 32'd8;
                    mask_d      = 2'b11;
                end
            end
            ST_WAIT: begin
                if (inst_rvalid_i) begin
                    state_d = ST_REQ;
                    rsp_ok  = !redirect;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (inst_rvalid_i) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect) begin
            fetch_pc_d = {target[31:3], 3'b000};
            mask_d     = first_mask(target);
        end
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_ok && fb_empty && !if_stall;
`else
    assign bypass = 1'b0;
`endif

    assign fb_push = rsp_ok && !bypass;
    assign fb_pop  = !fb_empty && !if_stall;

    always_comb begin
        out_entry = '0;
        if (bypass)        out_entry = rsp_entry;
        else if (!fb_empty) out_entry = fb_head;
    end

    assign if_valid_o = bypass || !fb_empty;
    assign if_pc_o    = out_entry.pc;
    assign if_inst_o  = out_entry.inst;
    assign if_mask_o  = out_entry.mask;

    fetch_buffer #(
        .DEPTH (FB_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (redirect),
        .push_i  (fb_push),
        .data_i  (rsp_entry),
        .pop_i   (fb_pop),
        .data_o  (fb_head),
        .count_o (fb_count),
        .full_o  (fb_full),
        .empty_o (fb_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            fetch_pc_q  <= {RESET_PC[31:3], 3'b000};
            mask_q      <= first_mask(RESET_PC);
            pend_pc_q   <= '0;
            pend_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            mask_q      <= mask_d;
            pend_pc_q   <= pend_pc_d;
            pend_mask_q <= pend_mask_d;
        end
    end

    // Only the IF stall bits and the pair-aligned target bits matter here.
    logic unused_bits;
    assign unused_bits = ^{stall1_i[6:2], stall1_i[0],
                           stall2_i[6:2], stall2_i[0], target[1:0]};

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed stimulus, queued expectations,
// a behavioural instruction memory and a monitor that checks every popped pair.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  stall1_i = '0;
    logic [6:0]  stall2_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_gnt_i = 1'b1;
    logic        inst_rvalid_i;
    logic [63:0] inst_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [63:0] if_inst_o;
    logic [1:0]  if_mask_o;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .FB_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall1_i      (stall1_i),
        .stall2_i      (stall2_i),
        .flush_i       (flush_i),
        .new_pc_i      (new_pc_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .inst_req_o    (inst_req_o),
        .inst_addr_o   (inst_addr_o),
        .inst_gnt_i    (inst_gnt_i),
        .inst_rvalid_i (inst_rvalid_i),
        .inst_rdata_i  (inst_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_mask_o     (if_mask_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    int    mem_lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {32'hB000_0000 ^ (a + 32'd4), 32'hA000_0000 ^ a};
    endfunction

    // Instruction memory: accepts on req&gnt, answers mem_lat cycles later.
    initial begin
        inst_rvalid_i = 1'b0;
        inst_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            inst_rvalid_i = 1'b0;
            inst_rdata_i  = '0;
            if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                inst_rvalid_i = 1'b1;
                inst_rdata_i  = mem_data(mq[0].addr);
                void'(mq.pop_front());
            end
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
            end else if (inst_req_o && inst_gnt_i) begin
                mq.push_back('{addr: inst_addr_o, due: cyc + mem_lat});
                acc_cnt++;
            end
        end
    end

    // Monitor: every pair consumed by IF/ID is checked against the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && if_valid_o && !(stall1_i[1] | stall2_i[1])) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pair got pc=%h mask=%b, none expected",
                         if_pc_o, if_mask_o);
            end else begin
                e = exp_q.pop_front();
                if (if_pc_o !== e.pc || if_inst_o !== e.inst ||
                    if_mask_o !== e.mask) begin
                    errors++;
                    $display("FAIL pair got pc=%h inst=%h mask=%b exp pc=%h inst=%h mask=%b",
                             if_pc_o, if_inst_o, if_mask_o, e.pc, e.inst, e.mask);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic expect_pair(input logic [31:0] pc, input logic [1:0] mask);
        exp_q.push_back('{pc: pc, inst: mem_data(pc), mask: mask});
    endtask

    task automatic do_reset(input logic [6:0] s1, input logic [6:0] s2,
                            input logic gnt, input int lat);
        step();
        rst_n         = 1'b0;
        stall1_i      = s1;
        stall2_i      = s2;
        inst_gnt_i    = gnt;
        mem_lat       = lat;
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        new_pc_i      = '0;
        branch_addr_i = '0;
        exp_q.delete();
        repeat (3) step();
        acc_cnt = 0;
        rst_n   = 1'b1;
        #2;
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        stall1_i = 7'h02;
        stall2_i = 7'h02;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pairs left exp 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) step();
        chk("rst_req",   64'(inst_req_o),  64'd0);
        chk("rst_addr",  64'(inst_addr_o), 64'h0);
        chk("rst_valid", 64'(if_valid_o),  64'd0);
        chk("rst_pc",    64'(if_pc_o),     64'h0);
        chk("rst_inst",  if_inst_o,        64'h0);
        chk("rst_mask",  64'(if_mask_o),   64'd0);

        // Sequential fetch, non-IF stall bits set must not stall.
        do_reset(7'h7C, 7'h00, 1'b1, 1);
        chk("t1_req",  64'(inst_req_o),  64'd1);
        chk("t1_addr", 64'(inst_addr_o), 64'h0);
        for (int i = 0; i < 8; i++) expect_pair(32'(i * 8), 2'b11);
        drain(100, "t1");

        // Both stalls: fill exactly FB_DEPTH, then drain in order.
        do_reset(7'h02, 7'h02, 1'b1, 1);
        repeat (20) step();
        chk("t2_acc",   64'(acc_cnt),    64'd4);
        chk("t2_req",   64'(inst_req_o), 64'd0);
        chk("t2_valid", 64'(if_valid_o), 64'd1);
        chk("t2_head",  64'(if_pc_o),    64'h0);
        for (int i = 0; i < 8; i++) expect_pair(32'(i * 8), 2'b11);
        stall1_i = 7'h00;
        stall2_i = 7'h00;
        drain(100, "t2");

        // Branch while waiting on a response.
        do_reset(7'h00, 7'h00, 1'b1, 3);
        expect_pair(32'h100, 2'b10);
        expect_pair(32'h108, 2'b11);
        expect_pair(32'h110, 2'b11);
        step();
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h104;
        step();
        branch_flag_i = 1'b0;
        #1;
        chk("t3_addr",  64'(inst_addr_o), 64'h100);
        chk("t3_req",   64'(inst_req_o),  64'd0);
        chk("t3_valid", 64'(if_valid_o),  64'd0);
        drain(200, "t3");

        // Flush beats a simultaneous branch.
        do_reset(7'h00, 7'h00, 1'b0, 1);
        expect_pair(32'h8,  2'b10);
        expect_pair(32'h10, 2'b11);
        expect_pair(32'h18, 2'b11);
        step();
        flush_i       = 1'b1;
        new_pc_i      = 32'h0000_000C;
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h204;
        step();
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        #1;
        chk("t4_addr", 64'(inst_addr_o), 64'h8);
        chk("t4_req",  64'(inst_req_o),  64'd1);
        inst_gnt_i = 1'b1;
        drain(100, "t4");

        // Flush in the same cycle as the response.
        do_reset(7'h00, 7'h00, 1'b1, 1);
        expect_pair(32'h40, 2'b11);
        expect_pair(32'h48, 2'b11);
        expect_pair(32'h50, 2'b11);
        step();
        flush_i  = 1'b1;
        new_pc_i = 32'h40;
        step();
        flush_i = 1'b0;
        #1;
        chk("t5_valid", 64'(if_valid_o),  64'd0);
        chk("t5_req",   64'(inst_req_o),  64'd1);
        chk("t5_addr",  64'(inst_addr_o), 64'h40);
        drain(100, "t5");

        // Asynchronous reset while a fetch is outstanding.
        do_reset(7'h02, 7'h02, 1'b1, 1);
        repeat (3) step();
        chk("t6_pre_valid", 64'(if_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req",   64'(inst_req_o),  64'd0);
        chk("t6_addr",  64'(inst_addr_o), 64'h0);
        chk("t6_valid", 64'(if_valid_o),  64'd0);
        chk("t6_pc",    64'(if_pc_o),     64'h0);
        chk("t6_inst",  if_inst_o,        64'h0);
        chk("t6_mask",  64'(if_mask_o),   64'd0);
        repeat (2) step();
        stall1_i = 7'h00;
        stall2_i = 7'h00;
        expect_pair(32'h0,  2'b11);
        expect_pair(32'h8,  2'b11);
        expect_pair(32'h10, 2'b11);
        rst_n = 1'b1;
        drain(100, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end of the dual-issue pipeline, sitting directly downstream of the pipeline controller. It owns the PC register and consumes the controller's stall vectors, flush and new_pc, plus the execute-stage branch redirect. It fetches aligned 64-bit instruction pairs from the instruction memory over a request/grant/response handshake, buffers them, and presents one pair per cycle to the IF/ID register.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FB_DEPTH, 4: fetch-buffer entries, power of two, at least 2.

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- stall1_i  in  7  controller stall vector, pipe 1; bit 1 = IF stall
- stall2_i  in  7  controller stall vector, pipe 2; bit 1 = IF stall
- flush_i  in  1  exception flush from controller
- new_pc_i  in  32  exception target, valid with flush_i
- branch_flag_i  in  1  taken-branch redirect from EX
- branch_addr_i  in  32  branch target
- inst_req_o  out  1  fetch request
- inst_addr_o  out  32  fetch address, bits [2:0] always 0
- inst_gnt_i  in  1  request accepted this cycle
- inst_rvalid_i  in  1  response data valid
- inst_rdata_i  in  64  {inst at addr+4, inst at addr}
- if_valid_o  out  1  pair at head of buffer is valid
- if_pc_o  out  32  address of slot 0 (8-byte aligned)
- if_inst_o  out  64  instruction pair
- if_mask_o  out  2  per-slot valid; 2'b10 when the fetch target had bit 2 set

## Operation
- FSM states: REQ, WAIT, DROP. Reset enters REQ. At most one request is outstanding.
- REQ: inst_req_o=1 while credit exists, i.e. buffer count + outstanding < FB_DEPTH. On inst_gnt_i, go to WAIT and advance fetch_pc by 8.
- WAIT: on inst_rvalid_i, push {pc, rdata, mask} into the buffer and return to REQ.
- DROP: discard the next inst_rvalid_i, then return to REQ.
- Redirect = flush_i (highest priority, target new_pc_i), else branch_flag_i (target branch_addr_i). On redirect:
  - clear the buffer;
  - set fetch_pc = target & ~7 and the first-pair mask = target[2] ? 2'b10 : 2'b11;
  - WAIT, or REQ with gnt this cycle, goes to DROP;
  - WAIT with rvalid this cycle drops the data and goes to REQ;
  - REQ without gnt stays in REQ with the new address.
- inst_addr_o changes while inst_req_o=1 only on a redirect.
- Pop the head when if_valid_o and IF stall (stall1_i[1] | stall2_i[1]) is 0. A stall holds all if_* outputs.
- Push and pop in the same cycle are legal, including when the buffer is full. Pointers wrap modulo FB_DEPTH.
- Redirect during DROP stays in DROP and updates the target.

## Timing
- Reset values:
  - inst_req_o=0, inst_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_mask_o=0.
  - FSM=REQ, buffer empty.
- First cycle after rst_n deasserts: inst_req_o=1, inst_addr_o=RESET_PC.
- Response at cycle M: if_valid_o=1 at M+1 (one-cycle latency).
- Redirect at cycle N: if_valid_o=0 at N+1. inst_addr_o=target at N+1 unless the FSM is in DROP.
- rst_n asserted mid-transaction: immediate return to reset values. Late responses after reset release are not expected from memory.

## Configuration
- FETCH_BYPASS_EN defined: an inst_rvalid_i arriving with the buffer empty, no stall and no redirect drives if_* combinationally in the same cycle and is not pushed. Zero-cycle latency.
- Undefined: all responses go through the buffer, giving the one-cycle latency above.

## Structure
- Shared package:
  - stall bit indices STALL_PC=0, STALL_IF=1;
  - FSM state enum;
  - fetch-entry struct {pc[31:0], inst[63:0], mask[1:0]};
  - default RESET_PC.
- Sub-module fetch_buffer: synchronous FIFO with FB_DEPTH entries and a synchronous clear, with push/pop/count/full/empty.

## Test plan
- Reset release with memory granting immediately, rvalid one cycle after gnt -> fetch addresses 0x0, 0x8, 0x10, ...; if_pc_o follows the same sequence; if_mask_o=2'b11.
- Both stalls held and memory always ready -> exactly FB_DEPTH pairs fetched, then inst_req_o=0. Release stall -> FB_DEPTH pops in order, then requests resume.
- branch_flag_i with branch_addr_i=0x104 while in WAIT -> pending response dropped; next inst_addr_o=0x100; first if_mask_o=2'b10; next pc 0x108.
- flush_i with new_pc_i=0x0000000C and branch_flag_i in the same cycle -> target 0x8, mask 2'b10, branch ignored.
- flush_i in the same cycle as inst_rvalid_i -> data not delivered; if_valid_o=0 next cycle; new request issued next cycle.
- rst_n pulsed low while in WAIT -> outputs at reset values immediately; refetch from RESET_PC after release.
